// File: rtl/mfp_sevenseg_mux_pkg.sv
// Shared glyph codes, active-low segment patterns and small helpers for the
// mfp_sevenseg_mux seven-segment driver.
package mfp_sevenseg_mux_pkg;

  typedef logic [4:0] glyph_t;
  typedef logic [6:0] seg_t;

  localparam glyph_t SS_BLANK = 5'h10;
  localparam glyph_t SS_DASH  = 5'h11;
  localparam glyph_t SS_UNDER = 5'h12;

  // Segment patterns, active-low, bit 0 = CA ... bit 6 = CG
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_UNDER = 7'h77;
  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Phase 0 is always dark so the previous digit's segments cannot ghost.
  function automatic logic phase_lit(input logic [3:0] phase, input logic [3:0] bright);
    return (phase != 4'd0) && (phase <= bright);
  endfunction

endpackage

// File: rtl/mfp_sevenseg_mux_if.sv
// Write bus from the GPIO/AHB register block into the display staging registers.
interface mfp_sevenseg_mux_if #(
  parameter int N_DIGITS = 8
) ();

  logic                    wr_en;
  logic [5*N_DIGITS-1:0]   wr_codes;
  logic [N_DIGITS-1:0]     wr_dp;
  logic [N_DIGITS-1:0]     wr_enable;
  logic [3:0]              wr_bright;

  modport master (
    output wr_en, wr_codes, wr_dp, wr_enable, wr_bright
  );

  modport slave (
    input  wr_en, wr_codes, wr_dp, wr_enable, wr_bright
  );

endinterface

// File: rtl/mfp_sevenseg_mux_decode.sv
// Combinational glyph decoder: 5-bit glyph code to active-low CA..CG pattern.
module mfp_sevenseg_decode
  import mfp_sevenseg_mux_pkg::*;
(
  input  glyph_t i_code,
  output seg_t   o_seg_n
);

  // Hex digits below 0x10, two special glyphs, everything else blank
  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_code)
      SS_DASH:  o_seg_n = SEG_DASH;
      SS_UNDER: o_seg_n = SEG_UNDER;
      default: begin
        if (i_code[4] == 1'b0) begin
          o_seg_n = SEG_HEX[i_code[3:0]];
        end else begin
          o_seg_n = SEG_BLANK;
        end
      end
    endcase
  end

endmodule

// File: rtl/mfp_sevenseg_mux.sv
// Time-multiplexed N-digit seven-segment driver with PWM brightness and
// staged updates that only take effect on a frame boundary.
module mfp_sevenseg_mux
  import mfp_sevenseg_mux_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV      = 390
) (
  input  logic                SI_ClkIn,
  input  logic                SI_Reset_N,
  mfp_sevenseg_mux_if.slave   wr,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [N_DIGITS-1:0] an_n,
  output logic                frame_tick,
  output logic                busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(N_DIGITS - 1);

  logic [PW-1:0]       r_pre;
  logic [3:0]          r_phase;
  logic [DW-1:0]       r_digit;

  glyph_t              r_stg_code  [N_DIGITS];
  logic [N_DIGITS-1:0] r_stg_dp;
  logic [N_DIGITS-1:0] r_stg_en;
  logic [3:0]          r_stg_bright;
  logic                r_pending;

  glyph_t              r_disp_code [N_DIGITS];
  logic [N_DIGITS-1:0] r_disp_dp;
  logic [N_DIGITS-1:0] r_disp_en;
  logic [3:0]          r_disp_bright;

  seg_t                r_seg_n;
  logic                r_dp_n;
  logic [N_DIGITS-1:0] r_an_n;
  logic                r_frame_tick;

  logic                w_pre_last;
  logic                w_slot_end;
  logic                w_boundary;
  glyph_t              w_code;
  seg_t                w_glyph;
  logic                w_lit;
  seg_t                w_seg_n;
  logic                w_dp_n;
  logic [N_DIGITS-1:0] w_an_n;

  assign w_pre_last = (r_pre == PRE_LAST);
  assign w_slot_end = w_pre_last && (r_phase == 4'hF);
  assign w_boundary = w_slot_end && (r_digit == DIG_LAST);

  // Prescaler, PWM phase and digit scan counters
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_pre   <= '0;
      r_phase <= 4'd0;
      r_digit <= '0;
    end else begin
      if (w_pre_last) begin
        r_pre   <= '0;
        r_phase <= r_phase + 4'd1;
      end else begin
        r_pre   <= r_pre + 1'b1;
      end
      if (w_slot_end) begin
        r_digit <= w_boundary ? '0 : r_digit + 1'b1;
      end
    end
  end

  // Staging registers; a write coinciding with a boundary stays pending
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int k = 0; k < N_DIGITS; k++) r_stg_code[k] <= SS_BLANK;
      r_stg_dp     <= '0;
      r_stg_en     <= '0;
      r_stg_bright <= 4'd0;
      r_pending    <= 1'b0;
    end else begin
      if (wr.wr_en) begin
        for (int k = 0; k < N_DIGITS; k++) r_stg_code[k] <= wr.wr_codes[5*k +: 5];
        r_stg_dp     <= wr.wr_dp;
        r_stg_en     <= wr.wr_enable;
        r_stg_bright <= wr.wr_bright;
        r_pending    <= 1'b1;
      end else if (w_boundary) begin
        r_pending    <= 1'b0;
      end
    end
  end

  // Display registers only change at the frame boundary
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int k = 0; k < N_DIGITS; k++) r_disp_code[k] <= SS_BLANK;
      r_disp_dp     <= '0;
      r_disp_en     <= '0;
      r_disp_bright <= 4'd0;
    end else if (w_boundary && r_pending) begin
      for (int k = 0; k < N_DIGITS; k++) r_disp_code[k] <= r_stg_code[k];
      r_disp_dp     <= r_stg_dp;
      r_disp_en     <= r_stg_en;
      r_disp_bright <= r_stg_bright;
    end
  end

  assign w_code = r_disp_code[r_digit];
  assign w_lit  = r_disp_en[r_digit] && phase_lit(r_phase, r_disp_bright);

  mfp_sevenseg_decode u_decode (
    .i_code  (w_code),
    .o_seg_n (w_glyph)
  );

  // Anode gating; segments and DP are blanked whenever the anode is off
  always_comb begin
    w_an_n  = '1;
    w_seg_n = SEG_BLANK;
    w_dp_n  = 1'b1;
    if (w_lit) begin
      w_an_n[r_digit] = 1'b0;
      w_seg_n         = w_glyph;
      w_dp_n          = ~r_disp_dp[r_digit];
    end else begin
      w_an_n  = '1;
      w_seg_n = SEG_BLANK;
      w_dp_n  = 1'b1;
    end
  end

  // Output registers driving the board pins
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_seg_n      <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg_n      <= w_seg_n;
      r_dp_n       <= w_dp_n;
      r_an_n       <= w_an_n;
      r_frame_tick <= w_boundary;
    end
  end

  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_tick = r_frame_tick;
  assign busy       = r_pending;

endmodule

// File: tb/tb_mfp_sevenseg_mux.sv
// Directed bench for mfp_sevenseg_mux: glyph/anode vector table plus
// hand-written frame timing, duty, tear-free, collision and reset sequences.
module tb_mfp_sevenseg_mux;

  localparam int N   = 8;
  localparam int DIV = 2;
  localparam int FRAME = 16 * DIV * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [7:0] an_n;
  logic       frame_tick;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;
  int cnt   [8];
  int first [8];
  int bad_a, bad_b, n_ticks;

  mfp_sevenseg_mux_if #(.N_DIGITS(N)) wr_if ();

  mfp_sevenseg_mux #(.N_DIGITS(N), .DIV(DIV)) dut (
    .SI_ClkIn   (clk),
    .SI_Reset_N (rst_n),
    .wr         (wr_if),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] codes;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [3:0]  bright;
    int          digit;
    int          phase;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [39:0] pack8(input logic [4:0] c7, c6, c5, c4, c3, c2, c1, c0);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after the next boundary edge (frame offset 0)
  task automatic wait_frame();
    int n;
    n = 0;
    tick();
    while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("frame_tick_seen", 32'(frame_tick), 32'd1);
  endtask

  task automatic count_to_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < 2 * FRAME);
  endtask

  task automatic do_write(input logic [39:0] codes, input logic [7:0] dp,
                          input logic [7:0] en, input logic [3:0] bright);
    wr_if.wr_codes  = codes;
    wr_if.wr_dp     = dp;
    wr_if.wr_enable = en;
    wr_if.wr_bright = bright;
    wr_if.wr_en     = 1'b1;
    tick();
    wr_if.wr_en     = 1'b0;
  endtask

  initial begin
    logic [39:0] g, e8, all1, all3, all5, all7, all2;
    g    = pack8(5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h11, 5'h01, 5'h00);
    e8   = pack8(5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08);
    all1 = pack8(5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01);
    all3 = pack8(5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03);
    all5 = pack8(5'h05, 5'h05, 5'h05, 5'h05, 5'h05, 5'h05, 5'h05, 5'h05);
    all7 = pack8(5'h07, 5'h07, 5'h07, 5'h07, 5'h07, 5'h07, 5'h07, 5'h07);
    all2 = pack8(5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02);

    vecs[0]  = '{g,  8'h00, 8'h07, 4'hF, 0, 1,  8'hFE, 7'h40, 1'b1};
    vecs[1]  = '{g,  8'h00, 8'h07, 4'hF, 1, 8,  8'hFD, 7'h79, 1'b1};
    vecs[2]  = '{g,  8'h00, 8'h07, 4'hF, 2, 15, 8'hFB, 7'h3F, 1'b1};
    vecs[3]  = '{g,  8'h00, 8'h07, 4'hF, 3, 5,  8'hFF, 7'h7F, 1'b1};
    vecs[4]  = '{g,  8'h00, 8'h07, 4'hF, 0, 0,  8'hFF, 7'h7F, 1'b1};
    vecs[5]  = '{e8, 8'h10, 8'hFF, 4'h4, 4, 4,  8'hEF, 7'h00, 1'b0};
    vecs[6]  = '{e8, 8'h10, 8'hFF, 4'h4, 4, 5,  8'hFF, 7'h7F, 1'b1};
    vecs[7]  = '{e8, 8'hFF, 8'hFF, 4'h0, 6, 1,  8'hFF, 7'h7F, 1'b1};
    vecs[8]  = '{pack8(5'h0A, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10),
                 8'h00, 8'hFF, 4'hF, 7, 3,  8'h7F, 7'h08, 1'b1};
    vecs[9]  = '{pack8(5'h10, 5'h10, 5'h12, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10),
                 8'h00, 8'hFF, 4'hF, 5, 2,  8'hDF, 7'h77, 1'b1};
    vecs[10] = '{pack8(5'h10, 5'h10, 5'h10, 5'h10, 5'h1F, 5'h10, 5'h10, 5'h10),
                 8'h00, 8'hFF, 4'hF, 3, 7,  8'hF7, 7'h7F, 1'b1};
    vecs[11] = '{pack8(5'h10, 5'h0E, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10),
                 8'h40, 8'hFF, 4'hC, 6, 10, 8'hBF, 7'h06, 1'b0};
    vecs[12] = '{pack8(5'h10, 5'h0E, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10),
                 8'h40, 8'hFF, 4'hC, 6, 13, 8'hFF, 7'h7F, 1'b1};
    vecs[13] = '{pack8(5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h0B, 5'h10),
                 8'h00, 8'h02, 4'hF, 1, 15, 8'hFD, 7'h03, 1'b1};

    wr_if.wr_en     = 1'b0;
    wr_if.wr_codes  = '0;
    wr_if.wr_dp     = '0;
    wr_if.wr_enable = '0;
    wr_if.wr_bright = 4'd0;

    // Reset state and first frame marker
    repeat (5) @(posedge clk);
    #1;
    check("rst_an_n", 32'(an_n), 32'hFF);
    check("rst_seg_n", 32'(seg_n), 32'h7F);
    check("rst_dp_n", 32'(dp_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_frame(n_ticks);
    check("first_frame_cycle", 32'(n_ticks), 32'(FRAME));
    count_to_frame(n_ticks);
    check("frame_period", 32'(n_ticks), 32'(FRAME));

    // Table of glyph / anode vectors
    for (int i = 0; i < 14; i++) begin
      wait_frame();
      do_write(vecs[i].codes, vecs[i].dp, vecs[i].en, vecs[i].bright);
      wait_frame();
      tick(vecs[i].digit * 16 * DIV + vecs[i].phase * DIV + 1);
      check($sformatf("vec%0d_an_n", i), 32'(an_n), 32'(vecs[i].exp_an));
      check($sformatf("vec%0d_seg_n", i), 32'(seg_n), 32'(vecs[i].exp_seg));
      check($sformatf("vec%0d_dp_n", i), 32'(dp_n), 32'(vecs[i].exp_dp));
    end

    // Brightness 4: each anode low for 4*DIV cycles starting at phase 1
    wait_frame();
    do_write(e8, 8'h00, 8'hFF, 4'h4);
    wait_frame();
    for (int d = 0; d < 8; d++) begin
      cnt[d] = 0;
      first[d] = -1;
    end
    bad_a = 0;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      for (int d = 0; d < 8; d++) begin
        if (an_n[d] == 1'b0) begin
          cnt[d]++;
          if (first[d] < 0) first[d] = k;
        end
      end
      if (an_n == 8'hFF && (seg_n != 7'h7F || dp_n != 1'b1)) bad_a++;
    end
    for (int d = 0; d < 8; d++) check($sformatf("duty_digit%0d", d), 32'(cnt[d]), 32'(4 * DIV));
    check("duty_start_d0", 32'(first[0]), 32'(DIV + 1));
    check("duty_start_d7", 32'(first[7]), 32'(7 * 16 * DIV + DIV + 1));
    check("blank_when_dark", 32'(bad_a), 32'd0);

    // Brightness 0: dark for a full frame
    do_write(e8, 8'h00, 8'hFF, 4'h0);
    wait_frame();
    bad_a = 0;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      if (an_n != 8'hFF) bad_a++;
    end
    check("bright0_dark", 32'(bad_a), 32'd0);

    // Tear-free update
    do_write(all1, 8'h00, 8'hFF, 4'hF);
    wait_frame();
    tick(40);
    do_write(all3, 8'h00, 8'hFF, 4'hF);
    check("tear_busy_set", 32'(busy), 32'd1);
    bad_a = 0;
    bad_b = 0;
    n_ticks = 0;
    while (frame_tick !== 1'b1 && n_ticks < 2 * FRAME) begin
      tick();
      n_ticks++;
      if (an_n != 8'hFF && seg_n != 7'h79) bad_a++;
      if (frame_tick !== 1'b1 && busy !== 1'b1) bad_b++;
    end
    check("tear_frame_tick", 32'(frame_tick), 32'd1);
    check("tear_old_glyph", 32'(bad_a), 32'd0);
    check("tear_busy_held", 32'(bad_b), 32'd0);
    check("tear_busy_clr", 32'(busy), 32'd0);
    tick(DIV + 1);
    check("tear_new_an", 32'(an_n), 32'hFE);
    check("tear_new_seg", 32'(seg_n), 32'h30);

    // Collision: second write exactly on the boundary edge
    tick(40 - (DIV + 1));
    do_write(all5, 8'h00, 8'hFF, 4'hF);
    tick(FRAME - 1 - 41);
    wr_if.wr_codes = all7;
    wr_if.wr_en    = 1'b1;
    tick();
    wr_if.wr_en    = 1'b0;
    check("coll_frame_tick", 32'(frame_tick), 32'd1);
    check("coll_busy", 32'(busy), 32'd1);
    tick(DIV + 1);
    check("coll_first_seg", 32'(seg_n), 32'h12);
    wait_frame();
    check("coll_busy_clr", 32'(busy), 32'd0);
    tick(DIV + 1);
    check("coll_second_seg", 32'(seg_n), 32'h78);

    // Mid-frame reset during digit 5, phase 3 with a write pending
    wait_frame();
    tick(160);
    do_write(all2, 8'h00, 8'hFF, 4'hF);
    tick(5 * 16 * DIV + 3 * DIV + 1 - 161);
    check("pre_rst_an", 32'(an_n), 32'hDF);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an_n), 32'hFF);
    check("mid_rst_seg", 32'(seg_n), 32'h7F);
    check("mid_rst_dp", 32'(dp_n), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tick", 32'(frame_tick), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_frame(n_ticks);
    check("post_rst_frame", 32'(n_ticks), 32'(FRAME));
    check("post_rst_busy", 32'(busy), 32'd0);
    tick(DIV + 1);
    check("post_rst_dark", 32'(an_n), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
